desc_fetch_engine: RTL and testbench
====================================

DESC_FETCH_ENGINE -- requirements
Module: desc_fetch_engine

Interface
REQ-001 Parameter ADDR_W, 11, word-address width of the descriptor memory port.
REQ-002 Parameter MAX_CHAIN, 2047, number of descriptors processed per run before the engine forces a stop.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 csr_address  in  2  CSR word select; csr_read/csr_write in 1; csr_writedata in 32; csr_readdata out 32 (registered, 1-cycle read latency).
REQ-006 m_address  out  ADDR_W  descriptor memory word address; m_chipselect, m_write out 1; m_byteenable out 4; m_writedata out 32.
REQ-007 m_readdata  in  32  memory read data, valid exactly 1 cycle after m_chipselect=1 with m_write=0; no waitrequest.
REQ-008 desc_valid  out  1; desc_ready  in  1; desc_data  out  96  {len_ctrl, dst, src} to the downstream dispatcher.
REQ-009 cmpl_valid  in  1; cmpl_ready  out  1; cmpl_len  in  16; cmpl_err  in  1  dispatcher completion.
REQ-010 irq  out  1  level interrupt.

Function
REQ-011 Descriptor = 4 words at base B: +0 src, +1 dst, +2 len_ctrl (bits 15:0 length, 31 OWN, 30 IRQ_EN, 29 ERR), +3 next pointer (bits ADDR_W-1:0).
REQ-012 CSRs: 0 CONTROL (bit0 RUN, bit1 STOP_ON_ERR), 1 HEAD (next pointer, write only accepted when not busy), 2 STATUS (bit0 BUSY, bit1 STOPPED, bit2 ERROR, bit3 IRQ; writing 1 to bits 2/3 clears them), 3 COUNT (descriptors completed, 16-bit, wraps).
REQ-013 States: IDLE, FETCH, CHECK, ISSUE, WAIT_CMPL, WBACK, NEXT.
REQ-014 IDLE -> FETCH when RUN=1; RUN 0->1 edge clears STOPPED and loads the current pointer from HEAD.
REQ-015 FETCH issues 4 back-to-back reads at B..B+3 on consecutive cycles; data captured 1 cycle after each issue; CHECK is entered the cycle after the last word is captured (5 cycles total).
REQ-016 Address arithmetic is modulo 2^ADDR_W (B+3 wraps past the top of memory).
REQ-017 CHECK: OWN=0 -> IDLE, set STOPPED, clear BUSY; OWN=1 -> ISSUE.
REQ-018 ISSUE: desc_valid=1 with stable desc_data until desc_valid&desc_ready; then WAIT_CMPL.
REQ-019 WAIT_CMPL: cmpl_ready=1; cmpl_ready=0 in all other states; completion is accepted on cmpl_valid&cmpl_ready.
REQ-020 WBACK: single write to B+2, byteenable 4'hF, data = {OWN=0, IRQ_EN unchanged, ERR=cmpl_err, bits 28:16 unchanged, cmpl_len}.
REQ-021 NEXT: COUNT+=1; if IRQ_EN then IRQ=1; if cmpl_err then ERROR=1; pointer <= next field; go to IDLE with STOPPED=1 if RUN=0, (STOP_ON_ERR and cmpl_err), or MAX_CHAIN descriptors done this run; else FETCH.
REQ-022 RUN cleared mid-chain: the in-flight descriptor completes through NEXT; no descriptor is abandoned after issue.
REQ-023 Next pointer equal to the current base is legal; the loop terminates only via OWN=0, RUN=0 or MAX_CHAIN.
REQ-024 BUSY=1 in every state except IDLE; irq = STATUS.IRQ.
REQ-025 Simultaneous CSR clear of IRQ and a NEXT setting IRQ: the set wins.
REQ-026 At most one memory access per cycle; m_chipselect=0 when idle.

Reset
REQ-027 On reset_n=0, immediately: state IDLE; all CSRs 0; current pointer 0; desc_valid, cmpl_ready, m_chipselect, m_write, irq 0; desc_data, m_address, m_writedata 0; m_byteenable 4'hF; csr_readdata 0.
REQ-028 Reset mid-operation abandons any fetch, issue or writeback with no further memory access.

Structure
REQ-029 A shared package holds the state enum, the descriptor word offsets, the len_ctrl bit positions and the CSR offsets/bit positions.
REQ-030 One sub-module, desc_fetch_csr, holds the CSR registers, read mux and IRQ/ERROR set/clear logic; the FSM and memory sequencing stay in desc_fetch_engine.

Verification
REQ-031 Memory preloaded with a descriptor at 0x010 (OWN=1, len 64, next 0x020) and 0x020 (OWN=0); HEAD=0x010; RUN=1 -> one desc_valid with len 64, word 0x012 rewritten with OWN=0, then STOPPED=1, COUNT=1.
REQ-032 desc_ready held 0 for 10 cycles -> desc_valid and desc_data stable throughout; no memory access issued.
REQ-033 Descriptor at 0x7FE (reads 0x7FE, 0x7FF, 0x000, 0x001) -> addresses wrap, fields assembled correctly.
REQ-034 cmpl_err=1 with STOP_ON_ERR=1 on the first of a 3-descriptor chain -> ERR written back, ERROR=1, STOPPED=1, second descriptor not fetched.
REQ-035 IRQ_EN=1 descriptor completes -> irq=1; write STATUS with bit3 set -> irq=0 on the next cycle.
REQ-036 reset_n pulsed low during WAIT_CMPL -> all outputs at reset values, no writeback, BUSY=0.

Source files
------------

// File: rtl/desc_fetch_engine_pkg.sv
//==============================================================================
// Module : desc_fetch_engine_pkg
// Brief  : Shared types and field positions for the descriptor fetch engine.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package desc_fetch_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_CHECK     = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_CMPL = 3'd4,
        ST_WBACK     = 3'd5,
        ST_NEXT      = 3'd6
    } state_t;

    // Word offsets inside a 4-word descriptor
    localparam logic [2:0] OFF_SRC    = 3'd0;
    localparam logic [2:0] OFF_DST    = 3'd1;
    localparam logic [2:0] OFF_LEN    = 3'd2;
    localparam logic [2:0] OFF_NEXT   = 3'd3;
    localparam logic [2:0] DESC_WORDS = 3'd4;

    // len_ctrl word fields
    localparam int LC_OWN    = 31;
    localparam int LC_IRQ_EN = 30;
    localparam int LC_ERR    = 29;

    // CSR map
    localparam logic [1:0] CSR_CONTROL = 2'd0;
    localparam logic [1:0] CSR_HEAD    = 2'd1;
    localparam logic [1:0] CSR_STATUS  = 2'd2;
    localparam logic [1:0] CSR_COUNT   = 2'd3;

    localparam int CTRL_RUN         = 0;
    localparam int CTRL_STOP_ON_ERR = 1;

    localparam int STS_BUSY    = 0;
    localparam int STS_STOPPED = 1;
    localparam int STS_ERROR   = 2;
    localparam int STS_IRQ     = 3;

    // Returned len_ctrl: ownership handed back, error and length from the dispatcher
    function automatic logic [31:0] wback_word(input logic [31:0] lenc,
                                               input logic        err,
                                               input logic [15:0] len);
        logic [31:0] w;
        w         = lenc;
        w[LC_OWN] = 1'b0;
        w[LC_ERR] = err;
        w[15:0]   = len;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/desc_fetch_csr.sv
//==============================================================================
// Module : desc_fetch_csr
// Brief  : Control/status registers, read mux and sticky status set/clear.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module desc_fetch_csr
    import desc_fetch_engine_pkg::*;
#(
    parameter int ADDR_W = 11
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    input  logic              i_busy,
    input  logic              i_set_stopped,
    input  logic              i_set_err,
    input  logic              i_set_irq,
    input  logic              i_count_inc,
    output logic              o_run,
    output logic              o_stop_on_err,
    output logic              o_stopped,
    output logic              o_run_start,
    output logic              o_irq,
    output logic [ADDR_W-1:0] o_head
);

    logic              r_run;
    logic              r_stop_on_err;
    logic [ADDR_W-1:0] r_head;
    logic              r_stopped;
    logic              r_error;
    logic              r_irq;
    logic [15:0]       r_count;
    logic [31:0]       r_rdata;

    logic              w_ctrl_wr;
    logic              w_head_wr;
    logic              w_sts_wr;
    logic              w_run_start;
    logic [31:0]       w_rmux;
    logic              w_unused_wdata;

    assign w_ctrl_wr   = csr_write && (csr_address == CSR_CONTROL);
    assign w_head_wr   = csr_write && (csr_address == CSR_HEAD) && !i_busy;
    assign w_sts_wr    = csr_write && (csr_address == CSR_STATUS);
    assign w_run_start = w_ctrl_wr && csr_writedata[CTRL_RUN] && !r_run;

    assign w_unused_wdata = ^csr_writedata;

    always_comb begin
        w_rmux = '0;
        case (csr_address)
            CSR_CONTROL: begin
                w_rmux[CTRL_RUN]         = r_run;
                w_rmux[CTRL_STOP_ON_ERR] = r_stop_on_err;
            end
            CSR_HEAD:    w_rmux[ADDR_W-1:0] = r_head;
            CSR_STATUS: begin
                w_rmux[STS_BUSY]    = i_busy;
                w_rmux[STS_STOPPED] = r_stopped;
                w_rmux[STS_ERROR]   = r_error;
                w_rmux[STS_IRQ]     = r_irq;
            end
            CSR_COUNT:   w_rmux[15:0] = r_count;
            default:     w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run         <= 1'b0;
            r_stop_on_err <= 1'b0;
            r_head        <= '0;
            r_stopped     <= 1'b0;
            r_error       <= 1'b0;
            r_irq         <= 1'b0;
            r_count       <= '0;
            r_rdata       <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_run         <= csr_writedata[CTRL_RUN];
                r_stop_on_err <= csr_writedata[CTRL_STOP_ON_ERR];
            end
            if (w_head_wr) begin
                r_head <= csr_writedata[ADDR_W-1:0];
            end
            // Hardware set events take priority over software clears
            if (i_set_stopped) begin
                r_stopped <= 1'b1;
            end else if (w_run_start) begin
                r_stopped <= 1'b0;
            end
            if (i_set_err) begin
                r_error <= 1'b1;
            end else if (w_sts_wr && csr_writedata[STS_ERROR]) begin
                r_error <= 1'b0;
            end
            if (i_set_irq) begin
                r_irq <= 1'b1;
            end else if (w_sts_wr && csr_writedata[STS_IRQ]) begin
                r_irq <= 1'b0;
            end
            if (i_count_inc) begin
                r_count <= r_count + 16'd1;
            end
            if (csr_read) begin
                r_rdata <= w_rmux;
            end
        end
    end

    assign csr_readdata  = r_rdata;
    assign o_run         = r_run;
    assign o_stop_on_err = r_stop_on_err;
    assign o_stopped     = r_stopped;
    assign o_run_start   = w_run_start;
    assign o_irq         = r_irq;
    assign o_head        = r_head;

endmodule

`default_nettype wire

// File: rtl/desc_fetch_engine.sv
//==============================================================================
// Module : desc_fetch_engine
// Brief  : Walks a linked list of descriptors in memory, hands each to a
//          dispatcher and writes the completion status back.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module desc_fetch_engine
    import desc_fetch_engine_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int MAX_CHAIN = 2047
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [95:0]       desc_data,
    input  logic              cmpl_valid,
    output logic              cmpl_ready,
    input  logic [15:0]       cmpl_len,
    input  logic              cmpl_err,
    output logic              irq
);

    localparam int CHAIN_W = $clog2(MAX_CHAIN + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_cnt;
    logic [ADDR_W-1:0]  r_ptr;
    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [31:0]        r_lenc;
    logic [ADDR_W-1:0]  r_next;
    logic [15:0]        r_cmpl_len;
    logic               r_cmpl_err;
    logic [CHAIN_W-1:0] r_chain;

    logic               w_run;
    logic               w_stop_on_err;
    logic               w_stopped;
    logic               w_run_start;
    logic [ADDR_W-1:0]  w_head;
    logic               w_busy;
    logic               w_set_stopped;
    logic               w_set_err;
    logic               w_set_irq;
    logic               w_count_inc;
    logic               w_chain_last;
    logic [2:0]         w_word_idx;

    assign w_busy       = (r_state != ST_IDLE);
    assign w_chain_last = (r_chain == CHAIN_W'(MAX_CHAIN - 1));
    assign w_word_idx   = r_cnt - 3'd1;

    desc_fetch_csr #(
        .ADDR_W (ADDR_W)
    ) u_csr (
        .clk           (clk),
        .reset_n       (reset_n),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .i_busy        (w_busy),
        .i_set_stopped (w_set_stopped),
        .i_set_err     (w_set_err),
        .i_set_irq     (w_set_irq),
        .i_count_inc   (w_count_inc),
        .o_run         (w_run),
        .o_stop_on_err (w_stop_on_err),
        .o_stopped     (w_stopped),
        .o_run_start   (w_run_start),
        .o_irq         (irq),
        .o_head        (w_head)
    );

    always_comb begin
        w_state_nxt   = r_state;
        m_chipselect  = 1'b0;
        m_write       = 1'b0;
        m_address     = '0;
        m_byteenable  = 4'hF;
        m_writedata   = '0;
        desc_valid    = 1'b0;
        cmpl_ready    = 1'b0;
        w_set_stopped = 1'b0;
        w_set_err     = 1'b0;
        w_set_irq     = 1'b0;
        w_count_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A stop latches until software produces a fresh RUN edge
                if (w_run && !w_stopped) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (r_cnt < DESC_WORDS) begin
                    m_chipselect = 1'b1;
                    m_address    = r_ptr + ADDR_W'(r_cnt);
                end else begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_lenc[LC_OWN]) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_set_stopped = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                desc_valid = 1'b1;
                if (desc_ready) begin
                    w_state_nxt = ST_WAIT_CMPL;
                end
            end
            ST_WAIT_CMPL: begin
                cmpl_ready = 1'b1;
                if (cmpl_valid) begin
                    w_state_nxt = ST_WBACK;
                end
            end
            ST_WBACK: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = r_ptr + ADDR_W'(OFF_LEN);
                m_writedata  = wback_word(r_lenc, r_cmpl_err, r_cmpl_len);
                w_state_nxt  = ST_NEXT;
            end
            ST_NEXT: begin
                w_count_inc = 1'b1;
                w_set_irq   = r_lenc[LC_IRQ_EN];
                w_set_err   = r_cmpl_err;
                if (!w_run || (w_stop_on_err && r_cmpl_err) || w_chain_last) begin
                    w_set_stopped = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_lenc     <= '0;
            r_next     <= '0;
            r_cmpl_len <= '0;
            r_cmpl_err <= 1'b0;
            r_chain    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_run_start) begin
                        r_ptr <= w_head;
                    end
                end
                ST_FETCH: begin
                    r_cnt <= r_cnt + 3'd1;
                    // Read data returns one cycle behind its address
                    if (r_cnt != 3'd0) begin
                        case (w_word_idx)
                            OFF_SRC:  r_src  <= m_readdata;
                            OFF_DST:  r_dst  <= m_readdata;
                            OFF_LEN:  r_lenc <= m_readdata;
                            OFF_NEXT: r_next <= m_readdata[ADDR_W-1:0];
                            default:  ;
                        endcase
                    end
                end
                ST_WAIT_CMPL: begin
                    if (cmpl_valid) begin
                        r_cmpl_len <= cmpl_len;
                        r_cmpl_err <= cmpl_err;
                    end
                end
                ST_NEXT: begin
                    r_ptr   <= r_next;
                    r_chain <= r_chain + CHAIN_W'(1);
                end
                default: ;
            endcase
            if (w_run_start) begin
                r_chain <= '0;
            end
        end
    end

    assign desc_data = {r_lenc, r_dst, r_src};

endmodule

`default_nettype wire

// File: tb/tb_desc_fetch_engine.sv
//==============================================================================
// Module : tb_desc_fetch_engine
// Brief  : Directed self-checking bench for desc_fetch_engine.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_desc_fetch_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic [10:0] m_address;
    logic        m_chipselect;
    logic        m_write;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        desc_valid;
    logic        desc_ready;
    logic [95:0] desc_data;
    logic        cmpl_valid;
    logic        cmpl_ready;
    logic [15:0] cmpl_len;
    logic        cmpl_err;
    logic        irq;

    logic [31:0] mem [0:2047];
    logic [10:0] rd_log [0:255];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic        tb_we;
    logic [10:0] tb_waddr;
    logic [31:0] tb_wdata;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } csr_vec_t;

    localparam int NVEC = 9;
    csr_vec_t vecs [NVEC];

    always #5 clk = ~clk;

    desc_fetch_engine #(
        .ADDR_W    (11),
        .MAX_CHAIN (2047)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_byteenable  (m_byteenable),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_data     (desc_data),
        .cmpl_valid    (cmpl_valid),
        .cmpl_ready    (cmpl_ready),
        .cmpl_len      (cmpl_len),
        .cmpl_err      (cmpl_err),
        .irq           (irq)
    );

    // Memory model: 1-cycle read latency, byte-enabled writes, access log
    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end else if (m_chipselect && m_write) begin
            for (int b = 0; b < 4; b++) begin
                if (m_byteenable[b]) mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (m_chipselect && !m_write) begin
            m_readdata           <= mem[m_address];
            rd_log[rd_cnt % 256] <= m_address;
            rd_cnt               <= rd_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        @(negedge clk);
        csr_write     = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        @(negedge clk);
        csr_read    = 1'b0;
        d           = csr_readdata;
    endtask

    task automatic mem_put(input logic [10:0] a, input logic [31:0] d);
        tb_we    = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    task automatic put_desc(input logic [10:0] b, input logic [31:0] s, input logic [31:0] t,
                            input logic [31:0] lc, input logic [31:0] nx);
        mem_put(b,         s);
        mem_put(b + 11'd1, t);
        mem_put(b + 11'd2, lc);
        mem_put(b + 11'd3, nx);
    endtask

    task automatic start_chain(input logic [10:0] head, input logic [31:0] ctrl);
        csr_wr(2'd0, 32'h0);
        csr_wr(2'd1, {21'h0, head});
        csr_wr(2'd0, ctrl);
    endtask

    task automatic issue_desc(input string nm, input logic [95:0] exp, input int hold);
        int acc0;
        for (int i = 0; i < 100; i++) begin
            if (desc_valid) break;
            @(negedge clk);
        end
        check({nm, "_valid"}, desc_valid, 1'b1);
        check({nm, "_data"}, desc_data, exp);
        acc0 = rd_cnt + wr_cnt;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("%s_hold%0d", nm, h), {desc_valid, cmpl_ready, desc_data}, {2'b10, exp});
        end
        if (hold > 0) check({nm, "_hold_noacc"}, rd_cnt + wr_cnt, acc0);
        desc_ready = 1'b1;
        @(negedge clk);
        desc_ready = 1'b0;
    endtask

    task automatic wait_cready(input string nm);
        for (int i = 0; i < 20; i++) begin
            if (cmpl_ready) break;
            @(negedge clk);
        end
        check({nm, "_cready"}, cmpl_ready, 1'b1);
    endtask

    task automatic complete_desc(input string nm, input logic [15:0] len, input logic err);
        wait_cready(nm);
        cmpl_valid = 1'b1;
        cmpl_len   = len;
        cmpl_err   = err;
        @(negedge clk);
        cmpl_valid = 1'b0;
        cmpl_err   = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        logic [31:0] d;
        d = 32'h1;
        for (int i = 0; i < 50; i++) begin
            csr_rd(2'd2, d);
            if (!d[0]) break;
        end
        check({nm, "_idle"}, d[0], 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          rd0;
        int          wr0;

        reset_n = 1'b0; csr_address = '0; csr_read = 1'b0; csr_write = 1'b0;
        csr_writedata = '0; desc_ready = 1'b0; cmpl_valid = 1'b0; cmpl_len = '0;
        cmpl_err = 1'b0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;

        vecs[0] = '{2'd0, 1'b0, 32'h0,        32'h0};
        vecs[1] = '{2'd1, 1'b0, 32'h0,        32'h0};
        vecs[2] = '{2'd2, 1'b0, 32'h0,        32'h0};
        vecs[3] = '{2'd3, 1'b0, 32'h0,        32'h0};
        vecs[4] = '{2'd1, 1'b1, 32'h0000_07FE, 32'h0000_07FE};
        vecs[5] = '{2'd1, 1'b1, 32'hFFFF_F123, 32'h0000_0123};
        vecs[6] = '{2'd0, 1'b1, 32'h0000_0002, 32'h0000_0002};
        vecs[7] = '{2'd0, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{2'd2, 1'b1, 32'h0000_000F, 32'h0000_0000};

        repeat (3) @(negedge clk);
        check("rst_ctl", {desc_valid, cmpl_ready, m_chipselect, m_write, irq, m_byteenable}, {5'b0, 4'hF});
        check("rst_mem_bus", {m_address, m_writedata}, 43'h0);
        check("rst_desc_data", desc_data, 96'h0);
        check("rst_rdata", csr_readdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].wr) csr_wr(vecs[i].addr, vecs[i].wdata);
            csr_rd(vecs[i].addr, d);
            check($sformatf("csr_vec%0d", i), d, vecs[i].exp);
        end

        // A: single owned descriptor, stall on desc_ready, stop on un-owned successor
        put_desc(11'h010, 32'hAAAA_0001, 32'hBBBB_0002, 32'h8000_0040, 32'h0000_0020);
        put_desc(11'h020, 32'h0000_00C1, 32'h0000_00C2, 32'h0000_0000, 32'h0000_0030);
        rd0 = rd_cnt; wr0 = wr_cnt;
        start_chain(11'h010, 32'h1);
        issue_desc("a", {32'h8000_0040, 32'hBBBB_0002, 32'hAAAA_0001}, 10);
        csr_wr(2'd1, 32'h0000_0555);
        complete_desc("a", 16'h0040, 1'b0);
        wait_idle("a");
        check("a_wback", mem[11'h012], 32'h0000_0040);
        check("a_reads", rd_cnt - rd0, 8);
        check("a_writes", wr_cnt - wr0, 1);
        check("a_rdaddr", {rd_log[(rd0 + 3) % 256], rd_log[(rd0 + 4) % 256]}, {11'h013, 11'h020});
        csr_rd(2'd2, d); check("a_status", d, 32'h2);
        csr_rd(2'd3, d); check("a_count", d, 32'h1);
        csr_rd(2'd1, d); check("a_head_locked", d, 32'h010);
        check("a_irq", irq, 1'b0);

        // B: descriptor straddling the top of memory, IRQ_EN set
        put_desc(11'h7FE, 32'h1111_2222, 32'h3333_4444, 32'hC000_0010, 32'h0000_0030);
        put_desc(11'h030, 32'h0, 32'h0, 32'h0, 32'h0);
        rd0 = rd_cnt;
        start_chain(11'h7FE, 32'h1);
        issue_desc("b", {32'hC000_0010, 32'h3333_4444, 32'h1111_2222}, 0);
        complete_desc("b", 16'h0020, 1'b0);
        wait_idle("b");
        check("b_rdaddr", {rd_log[rd0 % 256], rd_log[(rd0 + 1) % 256], rd_log[(rd0 + 2) % 256],
                           rd_log[(rd0 + 3) % 256]}, {11'h7FE, 11'h7FF, 11'h000, 11'h001});
        check("b_wback", mem[11'h000], 32'h4000_0020);
        check("b_irq_set", irq, 1'b1);
        csr_rd(2'd2, d); check("b_status", d, 32'hA);
        csr_wr(2'd2, 32'h8);
        check("b_irq_clr", irq, 1'b0);
        csr_rd(2'd2, d); check("b_status_clr", d, 32'h2);
        csr_rd(2'd3, d); check("b_count", d, 32'h2);

        // C: error completion with STOP_ON_ERR on a 3-descriptor chain
        put_desc(11'h100, 32'h1, 32'h2, 32'h8000_0008, 32'h0000_0104);
        put_desc(11'h104, 32'h3, 32'h4, 32'h8000_0008, 32'h0000_0108);
        put_desc(11'h108, 32'h5, 32'h6, 32'h8000_0008, 32'h0000_010C);
        rd0 = rd_cnt;
        start_chain(11'h100, 32'h3);
        issue_desc("c", {32'h8000_0008, 32'h2, 32'h1}, 0);
        complete_desc("c", 16'h0008, 1'b1);
        wait_idle("c");
        check("c_wback", mem[11'h102], 32'h2000_0008);
        check("c_second_untouched", mem[11'h106], 32'h8000_0008);
        check("c_reads", rd_cnt - rd0, 4);
        csr_rd(2'd2, d); check("c_status", d, 32'h6);
        csr_rd(2'd3, d); check("c_count", d, 32'h3);
        csr_wr(2'd2, 32'h4);
        csr_rd(2'd2, d); check("c_status_clr", d, 32'h2);

        // E: descriptor pointing at itself ends when ownership comes back cleared
        put_desc(11'h300, 32'h5, 32'h6, 32'h8000_0004, 32'h0000_0300);
        rd0 = rd_cnt;
        start_chain(11'h300, 32'h1);
        issue_desc("e", {32'h8000_0004, 32'h6, 32'h5}, 0);
        complete_desc("e", 16'h0004, 1'b0);
        wait_idle("e");
        check("e_reads", rd_cnt - rd0, 8);
        check("e_refetch", {rd_log[(rd0 + 4) % 256], rd_log[(rd0 + 7) % 256]}, {11'h300, 11'h303});
        check("e_wback", mem[11'h302], 32'h0000_0004);
        csr_rd(2'd3, d); check("e_count", d, 32'h4);

        // F: RUN cleared while a descriptor is in flight
        put_desc(11'h400, 32'h7, 32'h8, 32'h8000_0010, 32'h0000_0404);
        put_desc(11'h404, 32'h9, 32'hA, 32'h8000_0010, 32'h0000_0408);
        rd0 = rd_cnt;
        start_chain(11'h400, 32'h1);
        issue_desc("f", {32'h8000_0010, 32'h8, 32'h7}, 0);
        csr_wr(2'd0, 32'h0);
        complete_desc("f", 16'h0010, 1'b0);
        wait_idle("f");
        check("f_reads", rd_cnt - rd0, 4);
        check("f_wback", mem[11'h402], 32'h0000_0010);
        check("f_next_untouched", mem[11'h406], 32'h8000_0010);
        csr_rd(2'd2, d); check("f_status", d, 32'h2);
        csr_rd(2'd3, d); check("f_count", d, 32'h5);

        // D: asynchronous reset while waiting for completion
        put_desc(11'h200, 32'h1, 32'h2, 32'h8000_0001, 32'h0000_0204);
        start_chain(11'h200, 32'h1);
        issue_desc("d", {32'h8000_0001, 32'h2, 32'h1}, 0);
        wait_cready("d");
        wr0 = wr_cnt;
        #2 reset_n = 1'b0;
        #1;
        check("d_rst_ctl", {desc_valid, cmpl_ready, m_chipselect, m_write, irq, m_byteenable}, {5'b0, 4'hF});
        check("d_rst_mem_bus", {m_address, m_writedata}, 43'h0);
        check("d_rst_desc_data", desc_data, 96'h0);
        check("d_rst_rdata", csr_readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("d_no_wback", wr_cnt - wr0, 0);
        check("d_mem_kept", mem[11'h202], 32'h8000_0001);
        csr_rd(2'd2, d); check("d_status", d, 32'h0);
        csr_rd(2'd3, d); check("d_count", d, 32'h0);
        csr_rd(2'd0, d); check("d_control", d, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
